// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one-entry fetch slot with a three-state request FSM and redirect handling.
// Optional fetch address checking is compiled in with `define IFU_ADDR_CHECK_EN.
module ifu_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NAddr,
  input  logic        stall,
  input  logic        Req,
  input  logic        eret,
  input  logic [31:0] EPC,
  input  logic        IsBranch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic        F_valid,
  output logic [4:0]  F_ExcCode,
  output logic        F_BD,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, instr_nxt, req_addr, redirect_pc;
  logic        valid_nxt, bd_nxt, redirect, addr_bad, req_int;
  logic [4:0]  exc_nxt;

  assign redirect    = Req | eret;
  assign redirect_pc = Req ? EXC_PC : EPC;

`ifdef IFU_ADDR_CHECK_EN
  assign addr_bad = (F_PC[1:0] != 2'b00) || (F_PC < 32'h0000_3000) || (F_PC > 32'h0000_6FFC);
`else
  assign addr_bad = 1'b0;
`endif

  // A drained request must keep presenting the address it was issued with.
  assign imem_req  = req_int & ~reset;
  assign imem_addr = (state == DRAIN) ? req_addr : F_PC;
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    pc_nxt    = F_PC;
    instr_nxt = F_Instr;
    valid_nxt = F_valid;
    bd_nxt    = F_BD;
    exc_nxt   = F_ExcCode;
    req_int   = 1'b0;
    case (state)
      FETCH: begin
        req_int = ~addr_bad;
        if (redirect) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
          bd_nxt    = 1'b0;
          exc_nxt   = '0;
          state_nxt = (imem_ack || addr_bad) ? FETCH : DRAIN;
        end else if (addr_bad) begin
          instr_nxt = '0;
          exc_nxt   = EXC_ADEL;
          valid_nxt = 1'b1;
          state_nxt = READY;
        end else if (imem_ack) begin
          instr_nxt = imem_rdata;
          exc_nxt   = '0;
          valid_nxt = 1'b1;
          state_nxt = READY;
        end
      end
      READY: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
          bd_nxt    = 1'b0;
          exc_nxt   = '0;
          state_nxt = FETCH;
        end else if (!stall) begin
          pc_nxt    = NAddr;
          bd_nxt    = IsBranch;
          valid_nxt = 1'b0;
          exc_nxt   = '0;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        req_int = 1'b1;
        if (redirect) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
          bd_nxt    = 1'b0;
          exc_nxt   = '0;
        end
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      F_PC      <= RESET_PC;
      F_Instr   <= '0;
      F_valid   <= 1'b0;
      F_ExcCode <= '0;
      F_BD      <= 1'b0;
      req_addr  <= RESET_PC;
    end else begin
      state     <= state_nxt;
      F_PC      <= pc_nxt;
      F_Instr   <= instr_nxt;
      F_valid   <= valid_nxt;
      F_ExcCode <= exc_nxt;
      F_BD      <= bd_nxt;
      if (state == FETCH) req_addr <= F_PC;
    end
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- NAddr  in  32  next fetch address, computed combinationally from F_PC by the next-address logic.
- stall  in  1  D-stage hazard stall; hold the current fetch slot.
- Req  in  1  CP0 exception/interrupt entry request.
- eret  in  1  exception return.
- EPC  in  32  return target for eret.
- IsBranch  in  1  the instruction being accepted by D is a branch or jump.
- imem_req  out  1  instruction memory request valid.
- imem_addr  out  32  instruction memory request address.
- imem_ack  in  1  instruction memory response valid, one cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- F_PC  out  32  PC of the fetch slot.
- F_Instr  out  32  fetched instruction.
- F_valid  out  1  fetch slot holds an instruction for D.
- F_ExcCode  out  5  fetch exception code; 0 = none, 4 = AdEL.
- F_BD  out  1  fetch slot instruction is a branch delay slot.

Function
REQ-002 The FSM SHALL have three states: FETCH (request outstanding), READY (slot full), DRAIN (discarding a stale response).
REQ-003 In FETCH and DRAIN, imem_req SHALL be 1; otherwise it SHALL be 0. imem_addr SHALL hold its value from request issue until imem_ack.
REQ-004 In FETCH, imem_addr SHALL equal F_PC.
REQ-005 On FETCH with imem_ack=1, the block SHALL set F_Instr<=imem_rdata and F_valid<=1, and go to READY; latency from request to slot SHALL be one cycle after ack.
REQ-006 In READY with stall=0, the block SHALL set F_PC<=NAddr, F_BD<=IsBranch and F_valid<=0, and go to FETCH.
REQ-007 In READY with stall=1, all state and outputs SHALL hold.
REQ-008 Redirect priority SHALL be Req > eret > stall > normal advance. Req SHALL load F_PC with 0x0000_4180; eret SHALL load F_PC with EPC.
REQ-009 On any redirect: F_valid<=0, F_BD<=0, F_ExcCode<=0.
REQ-010 Redirect in READY SHALL go to FETCH.
REQ-011 Redirect in FETCH with imem_ack=0 SHALL go to DRAIN.
REQ-012 Redirect in FETCH with imem_ack=1 SHALL discard the data and go to FETCH.
REQ-013 In DRAIN, imem_addr SHALL keep the old address; on imem_ack the data SHALL be dropped and the state SHALL go to FETCH at the new F_PC.
REQ-014 A redirect in DRAIN SHALL update F_PC only, and the state SHALL remain in DRAIN.
REQ-015 stall SHALL be ignored in FETCH and DRAIN.

Reset
REQ-016 Reset assertion SHALL immediately set F_PC=0x0000_3000, F_Instr=0, F_valid=0, F_ExcCode=0, F_BD=0 and state=FETCH. imem_req SHALL be 0 while reset is high.
REQ-017 The first request SHALL issue in the first cycle after reset deasserts.
REQ-018 Reset during DRAIN or FETCH SHALL abandon the outstanding request; a late imem_ack arriving during reset SHALL be ignored.

Configuration
REQ-019 The macro IFU_ADDR_CHECK_EN SHALL control fetch address checking.
- Defined: in FETCH, if F_PC[1:0]!=0 or F_PC is outside 0x3000..0x6FFC, no request SHALL issue (imem_req=0). Next cycle: F_Instr<=0, F_ExcCode<=4, F_valid<=1, go to READY.
- Undefined: no check; F_ExcCode SHALL be constant 0.

Verification
REQ-020 Reset, then ack with rdata 0x2408_0001 in cycle 2 -> imem_addr=0x3000; F_Instr=0x2408_0001, F_valid=1, F_PC=0x3000.
REQ-021 READY, stall=1 for 3 cycles, then 0 with NAddr=0x3004 and IsBranch=1 -> outputs held for 3 cycles; then F_PC=0x3004, F_BD=1, and a new request issues at 0x3004.
REQ-022 Req=1 and eret=1 together in READY -> F_PC=0x4180, F_valid=0, F_BD=0.
REQ-023 eret with EPC=0x3010 in FETCH before ack, ack 2 cycles later with rdata 0xDEAD_BEEF -> DRAIN holds imem_addr at the old address; 0xDEAD_BEEF is never on F_Instr; the next request is at 0x3010.
REQ-024 IFU_ADDR_CHECK_EN defined, NAddr=0x3002 accepted -> imem_req stays 0; F_ExcCode=4, F_Instr=0, F_valid=1.
REQ-025 IFU_ADDR_CHECK_EN undefined, same stimulus -> request issues at 0x3002; F_ExcCode=0.
